// File: rtl/alu_fsm_pkg.sv
// Shared types and constants for the narrow-bus ALU sequencer and its helpers.
package alu_fsm_pkg;

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    EXEC    = 3'd3,
    SHOW    = 3'd4
  } state_t;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_AND   = 3'd2;
  localparam logic [2:0] OP_OR    = 3'd3;
  localparam logic [2:0] OP_XOR   = 3'd4;
  localparam logic [2:0] OP_SHL   = 3'd5;
  localparam logic [2:0] OP_SHR   = 3'd6;
  localparam logic [2:0] OP_PASSB = 3'd7;

  localparam int unsigned ACC_BIT = 3;

  // Beat counter width; a single-beat operand still needs one counter bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/alu_fsm_seq_if.sv
// Pin-side bundle of the ALU sequencer: strobe, data beat in, result beat and flags out.
interface alu_fsm_seq_if #(
  parameter int unsigned DIN_W = 4
);
  logic             ctl;
  logic [DIN_W-1:0] din;
  logic [DIN_W-1:0] res;
  logic             cout;
  logic             zero;
  logic [2:0]       phase;

  modport master (output ctl, din, input res, cout, zero, phase);
  modport slave  (input ctl, din, output res, cout, zero, phase);
endinterface

// File: rtl/alu_fsm_seq_ctl_strobe_sync.sv
// Two-flop synchroniser for an asynchronous pin strobe plus a one-cycle rising-edge pulse.
module ctl_strobe_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic pulse
);
  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign pulse = s2 & ~s3;
endmodule

// File: rtl/alu_fsm_seq.sv
// Multi-beat ALU sequencer: loads A, B and opcode over a narrow bus, executes, then shows the result beat by beat.
module alu_fsm_seq
  import alu_fsm_pkg::*;
#(
  parameter int unsigned DIN_W  = 4,
  parameter int unsigned NBEATS = 2
) (
  input  logic          clk,
  input  logic          rst,
  alu_fsm_seq_if.slave  bus
);
  localparam int unsigned W  = DIN_W * NBEATS;
  localparam int unsigned CW = cnt_w(NBEATS);
  localparam logic [CW-1:0] LAST = CW'(NBEATS - 1);

  logic strobe;

  ctl_strobe_sync u_sync (
    .clk      (clk),
    .rst_n    (rst),
    .async_in (bus.ctl),
    .pulse    (strobe)
  );

  state_t        state, state_n;
  logic [CW-1:0] beat_cnt, beat_n;
  logic [W-1:0]  a, a_n, b, b_n, r, r_n;
  logic [2:0]    op, op_n;
  logic          acc, acc_n, cout_q, cout_n, zero_q, zero_n;

  logic [W:0]    sum;
  logic [W-1:0]  alu_r;
  logic          alu_c;

  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    alu_r = '0;
    alu_c = 1'b0;
    case (op)
      OP_ADD:   begin alu_r = sum[W-1:0]; alu_c = sum[W]; end
      OP_SUB:   begin alu_r = a - b;      alu_c = (a >= b); end
      OP_AND:   alu_r = a & b;
      OP_OR:    alu_r = a | b;
      OP_XOR:   alu_r = a ^ b;
      OP_SHL:   begin alu_r = a << 1;     alu_c = a[W-1]; end
      OP_SHR:   begin alu_r = a >> 1;     alu_c = a[0]; end
      OP_PASSB: alu_r = b;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= LOAD_A;
      beat_cnt <= '0;
      a        <= '0;
      b        <= '0;
      r        <= '0;
      op       <= '0;
      acc      <= 1'b0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state    <= state_n;
      beat_cnt <= beat_n;
      a        <= a_n;
      b        <= b_n;
      r        <= r_n;
      op       <= op_n;
      acc      <= acc_n;
      cout_q   <= cout_n;
      zero_q   <= zero_n;
    end
  end

  // Shift-and-or form of {reg[W-DIN_W-1:0], din}; stays legal when NBEATS is 1.
  always_comb begin
    state_n = state;
    beat_n  = beat_cnt;
    a_n     = a;
    b_n     = b;
    r_n     = r;
    op_n    = op;
    acc_n   = acc;
    cout_n  = cout_q;
    zero_n  = zero_q;
    case (state)
      LOAD_A: if (strobe) begin
        a_n = (a << DIN_W) | W'(bus.din);
        if (beat_cnt == LAST) begin
          beat_n  = '0;
          state_n = LOAD_B;
        end else begin
          beat_n = beat_cnt + CW'(1);
        end
      end
      LOAD_B: if (strobe) begin
        b_n = (b << DIN_W) | W'(bus.din);
        if (beat_cnt == LAST) begin
          beat_n  = '0;
          state_n = LOAD_OP;
        end else begin
          beat_n = beat_cnt + CW'(1);
        end
      end
      LOAD_OP: if (strobe) begin
        op_n    = bus.din[2:0];
        acc_n   = bus.din[ACC_BIT];
        state_n = EXEC;
      end
      EXEC: begin
        r_n     = alu_r;
        cout_n  = alu_c;
        zero_n  = (alu_r == '0);
        beat_n  = '0;
        state_n = SHOW;
      end
      SHOW: if (strobe) begin
        if (beat_cnt == LAST) begin
          beat_n = '0;
          if (acc) begin
            a_n     = r;
            state_n = LOAD_B;
          end else begin
            state_n = LOAD_A;
          end
        end else begin
          beat_n = beat_cnt + CW'(1);
        end
      end
      default: state_n = LOAD_A;
    endcase
  end

  assign bus.res   = (state == SHOW)
                   ? DIN_W'(r >> (DIN_W * (NBEATS - 1 - 32'(beat_cnt))))
                   : '0;
  assign bus.cout  = cout_q;
  assign bus.zero  = zero_q;
  assign bus.phase = state;
endmodule

// File: tb/tb_alu_fsm_seq.sv
// Bench for alu_fsm_seq: directed cases, strobe-timing cases, randomized transactions and a parameter sweep.
module tb_alu_fsm_seq;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] ctl_v = '0;
  logic [3:0] din0 = '0;
  logic [3:0] din1 = '0;
  logic [7:0] din2 = '0;

  int checks = 0;
  int errors = 0;

  // Reference-model state for accumulate chaining on the 8-bit instance.
  bit         m_chain = 1'b0;
  logic [7:0] m_a = '0;

  always #5 clk = ~clk;

  alu_fsm_seq_if #(.DIN_W(4)) if0 ();
  alu_fsm_seq_if #(.DIN_W(4)) if1 ();
  alu_fsm_seq_if #(.DIN_W(8)) if2 ();

  assign if0.ctl = ctl_v[0];
  assign if0.din = din0;
  assign if1.ctl = ctl_v[1];
  assign if1.din = din1;
  assign if2.ctl = ctl_v[2];
  assign if2.din = din2;

  alu_fsm_seq #(.DIN_W(4), .NBEATS(2)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  alu_fsm_seq #(.DIN_W(4), .NBEATS(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  alu_fsm_seq #(.DIN_W(8), .NBEATS(4)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #2ms;
    errors++;
    $error("FAIL timeout: bench did not complete within the expected time");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  function automatic void model(input longint unsigned a, input longint unsigned b,
                                input int unsigned op, input int unsigned w,
                                output longint unsigned r, output bit c);
    longint unsigned m = (64'd1 << w) - 64'd1;
    c = 1'b0;
    case (op)
      0: begin r = (a + b) & m; c = bit'((a + b) >> w); end
      1: begin r = (a - b) & m; c = (a >= b); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = (a << 1) & m; c = bit'(a >> (w - 1)); end
      6: begin r = a >> 1; c = bit'(a); end
      default: r = b;
    endcase
  endfunction

  task automatic pulse(input int which, input logic [7:0] d, input int hi, input int lo);
    @(negedge clk);
    case (which)
      0: din0 = d[3:0];
      1: din1 = d[3:0];
      default: din2 = d;
    endcase
    ctl_v[which] = 1'b1;
    repeat (hi) @(negedge clk);
    ctl_v[which] = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic send0(input logic [7:0] v);
    logic [7:0] hi_b, lo_b;
    hi_b = {4'h0, v[7:4]};
    lo_b = {4'h0, v[3:0]};
    pulse(0, hi_b, 4, 4);
    pulse(0, lo_b, 4, 4);
  endtask

  // One full transaction on the 8-bit instance; returns the result seen on the bus.
  task automatic txn0(input logic [7:0] a, input logic [7:0] b, input logic [3:0] opc,
                      output logic [7:0] r_obs, output logic c_obs);
    logic [7:0] ea, opb;
    longint unsigned er;
    bit ec;
    ea  = m_chain ? m_a : a;
    opb = {4'h0, opc};
    if (!m_chain) send0(a);
    send0(b);
    pulse(0, opb, 4, 4);
    model(64'(ea), 64'(b), int'(opc[2:0]), 8, er, ec);
    chk("show_phase", if0.phase, 3'd4);
    chk("res_hi", if0.res, 4'(er >> 4));
    chk("cout", if0.cout, ec);
    chk("zero", if0.zero, (er == 0));
    r_obs[7:4] = if0.res;
    c_obs = if0.cout;
    pulse(0, 8'h00, 4, 4);
    chk("res_lo", if0.res, 4'(er));
    r_obs[3:0] = if0.res;
    pulse(0, 8'h00, 4, 4);
    chk("end_phase", if0.phase, (opc[3] ? 3'd1 : 3'd0));
    chk("res_idle", if0.res, 4'h0);
    chk("cout_hold", if0.cout, ec);
    m_chain = opc[3];
    m_a = 8'(er);
  endtask

  initial begin
    logic [7:0] r;
    logic c;
    repeat (3) @(negedge clk);
    chk("rst_phase", if0.phase, 3'd0);
    chk("rst_res", if0.res, 4'h0);
    chk("rst_cout", if0.cout, 1'b0);
    chk("rst_zero", if0.zero, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    txn0(8'h9C, 8'h75, 4'h0, r, c);
    chk("add_r", r, 8'h11);
    chk("add_c", c, 1'b1);
    txn0(8'h10, 8'h20, 4'h1, r, c);
    chk("sub_r", r, 8'hF0);
    chk("sub_c", c, 1'b0);
    txn0(8'h20, 8'h20, 4'h1, r, c);
    chk("sub_eq_r", r, 8'h00);
    chk("sub_eq_zero", if0.zero, 1'b1);
    txn0(8'h81, 8'h00, 4'h5, r, c);
    chk("shl_r", r, 8'h02);
    chk("shl_c", c, 1'b1);
    txn0(8'h81, 8'h00, 4'h6, r, c);
    chk("shr_r", r, 8'h40);
    chk("shr_c", c, 1'b1);

    // Reset mid-load of B, released between clock edges.
    send0(8'h12);
    pulse(0, 8'h03, 4, 4);
    chk("midload_phase", if0.phase, 3'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_phase", if0.phase, 3'd0);
    chk("arst_res", if0.res, 4'h0);
    chk("arst_cout", if0.cout, 1'b0);
    #1 rst = 1'b1;
    m_chain = 1'b0;
    txn0(8'h01, 8'h01, 4'h0, r, c);
    chk("post_rst_r", r, 8'h02);

    // Accumulate chain.
    txn0(8'h05, 8'h03, 4'h8, r, c);
    chk("acc1_r", r, 8'h08);
    txn0(8'h00, 8'h02, 4'h0, r, c);
    chk("acc2_r", r, 8'h0A);

    // ctl held high for 50 cycles must capture one beat only.
    pulse(0, 8'h0A, 50, 4);
    chk("hold_phase", if0.phase, 3'd0);
    pulse(0, 8'h05, 4, 4);
    chk("hold_phase2", if0.phase, 3'd1);
    send0(8'h00);
    pulse(0, 8'h00, 4, 4);
    chk("hold_res_hi", if0.res, 4'hA);
    pulse(0, 8'h00, 4, 4);
    chk("hold_res_lo", if0.res, 4'h5);
    pulse(0, 8'h00, 4, 4);
    chk("hold_end", if0.phase, 3'd0);

    // Strobes two cycles apart, constant data.
    for (int unsigned i = 0; i < 4; i++) pulse(0, 8'h03, 1, 1);
    repeat (4) @(negedge clk);
    chk("fast_phase", if0.phase, 3'd2);
    pulse(0, 8'h00, 4, 4);
    chk("fast_res_hi", if0.res, 4'h6);
    pulse(0, 8'h00, 4, 4);
    chk("fast_res_lo", if0.res, 4'h6);
    pulse(0, 8'h00, 4, 4);

    // Randomized transactions against the reference model.
    for (int unsigned i = 0; i < 24; i++) begin
      logic [7:0] ra, rb;
      logic [3:0] ro;
      longint unsigned er;
      bit ec;
      logic [7:0] ea;
      ra = 8'($urandom);
      rb = 8'($urandom);
      ro = 4'($urandom);
      ea = m_chain ? m_a : ra;
      model(64'(ea), 64'(rb), int'(ro[2:0]), 8, er, ec);
      txn0(ra, rb, ro, r, c);
      chk("rand_r", r, 8'(er));
    end

    // Single-beat 4-bit instance: 0xF + 1.
    pulse(1, 8'h0F, 4, 4);
    chk("w4_phase_b", if1.phase, 3'd1);
    pulse(1, 8'h01, 4, 4);
    pulse(1, 8'h00, 4, 4);
    chk("w4_phase", if1.phase, 3'd4);
    chk("w4_res", if1.res, 4'h0);
    chk("w4_cout", if1.cout, 1'b1);
    chk("w4_zero", if1.zero, 1'b1);
    pulse(1, 8'h00, 4, 4);
    chk("w4_end", if1.phase, 3'd0);

    // 32-bit instance: 0xFFFFFFFF + 1.
    for (int unsigned i = 0; i < 4; i++) pulse(2, 8'hFF, 4, 4);
    for (int unsigned i = 0; i < 3; i++) pulse(2, 8'h00, 4, 4);
    pulse(2, 8'h01, 4, 4);
    pulse(2, 8'h00, 4, 4);
    chk("w32_phase", if2.phase, 3'd4);
    chk("w32_cout", if2.cout, 1'b1);
    chk("w32_zero", if2.zero, 1'b1);
    for (int unsigned i = 0; i < 4; i++) begin
      chk("w32_res", if2.res, 8'h00);
      pulse(2, 8'h00, 4, 4);
    end
    chk("w32_end", if2.phase, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
